// File: rtl/native_axil_master_if.sv
// AXI4-lite master-side bus bundle for native_axil_master.
// The master modport drives the valid/payload side and the slave modport the responder side.
interface native_axil_master_if;
  logic        mem_axi_awvalid;
  logic        mem_axi_awready;
  logic [31:0] mem_axi_awaddr;
  logic [2:0]  mem_axi_awprot;
  logic        mem_axi_wvalid;
  logic        mem_axi_wready;
  logic [31:0] mem_axi_wdata;
  logic [3:0]  mem_axi_wstrb;
  logic        mem_axi_bvalid;
  logic        mem_axi_bready;
  logic        mem_axi_arvalid;
  logic        mem_axi_arready;
  logic [31:0] mem_axi_araddr;
  logic [2:0]  mem_axi_arprot;
  logic        mem_axi_rvalid;
  logic        mem_axi_rready;
  logic [31:0] mem_axi_rdata;

  modport master (
    output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    output mem_axi_bready,
    output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    output mem_axi_rready,
    input  mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
    input  mem_axi_arready, mem_axi_rvalid, mem_axi_rdata
  );

  modport slave (
    input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
    input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
    input  mem_axi_bready,
    input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
    input  mem_axi_rready,
    output mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
    output mem_axi_arready, mem_axi_rvalid, mem_axi_rdata
  );
endinterface

// File: rtl/native_axil_master.sv
// Bridges a picorv32-style native valid/ready request onto an AXI4-lite master port.
// One transaction in flight; every AXI output and mem_ready come straight from flops.
module native_axil_master #(
  parameter logic [2:0] PROT_INSN = 3'b100,
  parameter logic [2:0] PROT_DATA = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        busy,
  native_axil_master_if.master axi
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t      r_state, w_nextState;
  logic        r_awValid, w_awValid;
  logic        r_wValid, w_wValid;
  logic        r_bReady, w_bReady;
  logic        r_arValid, w_arValid;
  logic        r_rReady, w_rReady;
  logic        r_memReady, w_memReady;
  logic [31:0] r_rdata, w_rdata;
  logic [31:0] r_addr, w_addr;
  logic [31:0] r_wdata, w_wdata;
  logic [3:0]  r_wstrb, w_wstrb;
  logic [2:0]  r_awProt, w_awProt;
  logic [2:0]  r_arProt, w_arProt;
  logic        r_awDone, w_awDone;
  logic        r_wDone, w_wDone;

  logic w_awFire, w_wFire, w_bFire, w_arFire, w_rFire;

  assign w_awFire = r_awValid & axi.mem_axi_awready;
  assign w_wFire  = r_wValid  & axi.mem_axi_wready;
  assign w_bFire  = r_bReady  & axi.mem_axi_bvalid;
  assign w_arFire = r_arValid & axi.mem_axi_arready;
  assign w_rFire  = r_rReady  & axi.mem_axi_rvalid;

  // The mem_ready guard keeps a request still held in the completion cycle from being re-issued.
  always_comb begin
    w_nextState = r_state;
    w_awValid   = r_awValid;
    w_wValid    = r_wValid;
    w_bReady    = r_bReady;
    w_arValid   = r_arValid;
    w_rReady    = r_rReady;
    w_memReady  = 1'b0;
    w_rdata     = r_rdata;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_wstrb     = r_wstrb;
    w_awProt    = r_awProt;
    w_arProt    = r_arProt;
    w_awDone    = r_awDone;
    w_wDone     = r_wDone;

    case (r_state)
      IDLE: begin
        if (mem_valid && !r_memReady) begin
          w_addr  = mem_addr;
          w_wdata = mem_wdata;
          w_wstrb = mem_wstrb;
          if (mem_wstrb != 4'b0000) begin
            w_nextState = WR;
            w_awValid   = 1'b1;
            w_wValid    = 1'b1;
            w_awProt    = PROT_DATA;
          end else begin
            w_nextState = RD_ADDR;
            w_arValid   = 1'b1;
            w_arProt    = mem_instr ? PROT_INSN : PROT_DATA;
          end
        end
      end
      WR: begin
        if (w_awFire) begin
          w_awValid = 1'b0;
          w_awDone  = 1'b1;
        end
        if (w_wFire) begin
          w_wValid = 1'b0;
          w_wDone  = 1'b1;
        end
        if (w_awDone && w_wDone) begin
          w_nextState = WR_RESP;
          w_bReady    = 1'b1;
          w_awDone    = 1'b0;
          w_wDone     = 1'b0;
        end
      end
      WR_RESP: begin
        if (w_bFire) begin
          w_nextState = IDLE;
          w_bReady    = 1'b0;
          w_memReady  = 1'b1;
        end
      end
      RD_ADDR: begin
        if (w_arFire) begin
          w_nextState = RD_DATA;
          w_arValid   = 1'b0;
          w_rReady    = 1'b1;
        end
      end
      RD_DATA: begin
        if (w_rFire) begin
          w_nextState = IDLE;
          w_rReady    = 1'b0;
          w_rdata     = axi.mem_axi_rdata;
          w_memReady  = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_awValid  <= 1'b0;
      r_wValid   <= 1'b0;
      r_bReady   <= 1'b0;
      r_arValid  <= 1'b0;
      r_rReady   <= 1'b0;
      r_memReady <= 1'b0;
      r_rdata    <= 32'h0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_wstrb    <= 4'h0;
      r_awProt   <= 3'b000;
      r_arProt   <= 3'b000;
      r_awDone   <= 1'b0;
      r_wDone    <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_awValid  <= w_awValid;
      r_wValid   <= w_wValid;
      r_bReady   <= w_bReady;
      r_arValid  <= w_arValid;
      r_rReady   <= w_rReady;
      r_memReady <= w_memReady;
      r_rdata    <= w_rdata;
      r_addr     <= w_addr;
      r_wdata    <= w_wdata;
      r_wstrb    <= w_wstrb;
      r_awProt   <= w_awProt;
      r_arProt   <= w_arProt;
      r_awDone   <= w_awDone;
      r_wDone    <= w_wDone;
    end
  end

  assign mem_ready           = r_memReady;
  assign mem_rdata           = r_rdata;
  assign busy                = (r_state != IDLE);
  assign axi.mem_axi_awvalid = r_awValid;
  assign axi.mem_axi_awaddr  = r_addr;
  assign axi.mem_axi_awprot  = r_awProt;
  assign axi.mem_axi_wvalid  = r_wValid;
  assign axi.mem_axi_wdata   = r_wdata;
  assign axi.mem_axi_wstrb   = r_wstrb;
  assign axi.mem_axi_bready  = r_bReady;
  assign axi.mem_axi_arvalid = r_arValid;
  assign axi.mem_axi_araddr  = r_addr;
  assign axi.mem_axi_arprot  = r_arProt;
  assign axi.mem_axi_rready  = r_rReady;

endmodule
